alu_share_arbiter: RTL and testbench

//  Shares the single execute-stage ALU between NUM_REQ requesters (e.g. main pipe, branch-compare, AGU).

---
 rtl/alu_share_arbiter_pkg.sv | 23 ++
 rtl/alu_rr_picker.sv | 44 ++++
 rtl/alu_share_arbiter.sv | 103 ++++++++++
 tb/tb_alu_share_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU control codes, arbiter state encoding and sizing helpers for alu_share_arbiter.
package alu_share_arbiter_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;

  // 2'b11 is deliberately left unnamed; the FSM treats it as illegal and recovers to ARB_IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_EXEC = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational requester picker: round-robin from rr_ptr, or fixed lowest-index
// priority when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_picker
  import alu_share_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && req_valid[i]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(i);
      end
    end
`else
    // Wrap by compare so non-power-of-2 NUM_REQ never aliases onto an unused index.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
`endif
    if (any_valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: IDLE -> EXEC -> RESP.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [ALU_CTRL_W*NUM_REQ-1:0] req_op,
  input  logic [XLEN*NUM_REQ-1:0]      req_a,
  input  logic [XLEN*NUM_REQ-1:0]      req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [XLEN-1:0]              rsp_data,
  output logic [ALU_CTRL_W-1:0]        alu_control,
  output logic [XLEN-1:0]              alu_a,
  output logic [XLEN-1:0]              alu_b,
  input  logic [XLEN-1:0]              alu_result,
  output logic                         busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e            state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, owner, winner;
  logic [NUM_REQ-1:0]    grant;
  logic                  any_valid;
  logic [ALU_CTRL_W-1:0] op_reg;
  logic [XLEN-1:0]       a_reg, b_reg, result_reg;

  alu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          req_ready = grant;
          state_nxt = ARB_EXEC;
        end
      end
      ARB_EXEC: state_nxt = ARB_RESP;
      ARB_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = ARB_IDLE;
      end
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && any_valid) begin
        owner  <= winner;
        op_reg <= req_op[ALU_CTRL_W*winner +: ALU_CTRL_W];
        a_reg  <= req_a[XLEN*winner +: XLEN];
        b_reg  <= req_b[XLEN*winner +: XLEN];
`ifdef ALU_ARB_FIXED_PRIO_EN
        rr_ptr <= '0;
`else
        rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
      end
      if (state == ARB_EXEC) result_reg <= alu_result;
    end
  end

  always_comb begin
    alu_control = '0;
    alu_a       = '0;
    alu_b       = '0;
    if (state == ARB_EXEC || state == ARB_RESP) begin
      alu_control = op_reg;
      alu_a       = a_reg;
      alu_b       = b_reg;
    end
  end

  assign rsp_data = result_reg;
  assign busy     = (state != ARB_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester instance and a 3-requester instance
// (wrap case), each driving a behavioural ALU.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-requester instance
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        busy;

  // 3-requester instance
  logic [2:0]  t_req_valid, t_req_ready, t_rsp_valid, t_rsp_ready;
  logic [8:0]  t_req_op;
  logic [95:0] t_req_a, t_req_b;
  logic [31:0] t_rsp_data, t_alu_a, t_alu_b, t_alu_result;
  logic [2:0]  t_alu_control;
  logic        t_busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
  );

  alu_share_arbiter #(.NUM_REQ(3), .XLEN(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_op(t_req_op), .req_a(t_req_a), .req_b(t_req_b), .rsp_valid(t_rsp_valid),
    .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .alu_control(t_alu_control),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_result(t_alu_result), .busy(t_busy)
  );

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_control, alu_a, alu_b);
  assign t_alu_result = alu_model(t_alu_control, t_alu_a, t_alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[3*i +: 3] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_op(input string tag, input int i, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'(1 << i);
    set_req(i, op, a, b);
    req_valid = oh;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(oh));
    tick;
    req_valid = '0;
    check({tag, "_exec_busy"}, 64'(busy), 64'd1);
    check({tag, "_alu_a"}, 64'(alu_a), 64'(a));
    check({tag, "_alu_ctl"}, 64'(alu_control), 64'(op));
    tick;
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp));
    rsp_ready = oh;
    tick;
    rsp_ready = '0;
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  logic [1:0]  exp_oh;
  logic [31:0] exp_d;

  initial begin
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    t_req_valid = '0; t_rsp_ready = '0; t_req_op = '0; t_req_a = '0; t_req_b = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_ctl", 64'(alu_control), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    tick;
    rst_n = 1'b1;

    // reset in the middle of EXEC
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid = 2'b01;
    tick;
    req_valid = '0;
    check("midrst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_alu_a", 64'(alu_a), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    check("midrst_no_result", 64'(rsp_data), 64'd0);

    do_op("add", 0, ALU_ADD, 32'd5, 32'd7, 32'd12);
    do_op("xor", 1, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    do_op("and", 0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    do_op("or",  1, ALU_OR,  32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0);

    // contention: both requesters held valid for four operations
    set_req(0, ALU_ADD, 32'd10, 32'd1);
    set_req(1, ALU_ADD, 32'd20, 32'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_oh = 2'b01;
`else
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_d = (exp_oh == 2'b01) ? 32'd11 : 32'd22;
      #1;
      check($sformatf("cont%0d_ready", k), 64'(req_ready), 64'(exp_oh));
      tick;
      check($sformatf("cont%0d_exec_ready", k), 64'(req_ready), 64'd0);
      tick;
      check($sformatf("cont%0d_rsp_valid", k), 64'(rsp_valid), 64'(exp_oh));
      check($sformatf("cont%0d_rsp_data", k), 64'(rsp_data), 64'(exp_d));
      rsp_ready = 2'b11;
      tick;
      rsp_ready = '0;
    end
    req_valid = '0;
    tick;

    // backpressure with a non-owner ready for part of the hold
    set_req(0, ALU_SUB, 32'd3, 32'd5);
    set_req(1, ALU_ADD, 32'd40, 32'd2);
    req_valid = 2'b01;
    #1;
    check("bp_ready", 64'(req_ready), 64'd1);
    tick;
    req_valid = 2'b10;
    tick;
    for (int k = 0; k < 5; k++) begin
      rsp_ready = (k >= 3) ? 2'b10 : 2'b00;
      check($sformatf("bp%0d_data", k), 64'(rsp_data), 64'hFFFF_FFFE);
      check($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d_no_grant", k), 64'(req_ready), 64'd0);
      tick;
    end
    check("bp_nonowner_busy", 64'(busy), 64'd1);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = '0;
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'd2);
    req_valid = '0;
    tick;

    // 3-requester wrap: 2, then 0 and 1 contending
    t_req_op[8:6] = ALU_ADD; t_req_a[95:64] = 32'd100; t_req_b[95:64] = 32'd1;
    t_req_valid = 3'b100;
    #1;
    check("wrap_ready2", 64'(t_req_ready), 64'd4);
    tick;
    t_req_valid = '0;
    tick;
    check("wrap_rsp2_valid", 64'(t_rsp_valid), 64'd4);
    check("wrap_rsp2_data", 64'(t_rsp_data), 64'd101);
    t_rsp_ready = 3'b100;
    tick;
    t_rsp_ready = '0;
    t_req_op[2:0] = ALU_ADD; t_req_a[31:0]  = 32'd1; t_req_b[31:0]  = 32'd1;
    t_req_op[5:3] = ALU_SUB; t_req_a[63:32] = 32'd9; t_req_b[63:32] = 32'd4;
    t_req_valid = 3'b011;
    #1;
    check("wrap_ready0", 64'(t_req_ready), 64'd1);
    tick;
    tick;
    check("wrap_rsp0_valid", 64'(t_rsp_valid), 64'd1);
    check("wrap_rsp0_data", 64'(t_rsp_data), 64'd2);
    t_rsp_ready = 3'b111;
    tick;
    t_rsp_ready = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("wrap_ready_next", 64'(t_req_ready), 64'd1);
    exp_d = 32'd2;
`else
    check("wrap_ready_next", 64'(t_req_ready), 64'd2);
    exp_d = 32'd5;
`endif
    tick;
    t_req_valid = '0;
    tick;
    check("wrap_rsp_next_data", 64'(t_rsp_data), 64'(exp_d));
    t_rsp_ready = 3'b111;
    tick;
    t_rsp_ready = '0;
    check("wrap_idle", 64'(t_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
